// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: ceiling-log2 and the pointer/count widths derived from a depth.
package fifo_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 8;

  typedef enum logic {
    ReadStd  = 1'b0,
    ReadFwft = 1'b1
  } read_mode_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth);
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the parametrised FIFO; slave is the FIFO side.
interface sync_fifo_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  import fifo_pkg::*;

  localparam int unsigned CntW = cnt_width(DEPTH);

  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             rd;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [CntW-1:0]  fifo_cnt;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, data_in, rd,
    input  data_out, empty, full, almost_full, almost_empty, fifo_cnt, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd,
    output data_out, empty, full, almost_full, almost_empty, fifo_cnt, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read. Contents are never reset.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/almost-empty levels and one-cycle overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam logic [CntW-1:0] AfLvl = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeLvl = CntW'(AE_LEVEL);
  localparam logic [CntW-1:0] Full  = CntW'(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty_q, full_q, af_q, ae_q, ovf_q, unf_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rdata;

  // An empty FIFO never bypasses a same-edge write, so rd_acc depends only on stored data.
  assign rd_acc = bus.rd && !empty_q;
  assign wr_acc = bus.wr && (!full_q || rd_acc);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + CntW'(1);
    else if (rd_acc && !wr_acc) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q   <= cnt_d;
      // Flags derive from the next count so they line up with the registered fifo_cnt.
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == Full);
      af_q    <= (cnt_d >= AfLvl);
      ae_q    <= (cnt_d <= AeLvl);
      ovf_q   <= bus.wr && !wr_acc;
      unf_q   <= bus.rd && empty_q;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AddrW (PtrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign bus.data_out = empty_q ? '0 : rdata;
  end else begin : g_std
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk) begin
      if (rst)         data_q <= '0;
      else if (rd_acc) data_q <= rdata;
    end
    assign bus.data_out = data_q;
  end

  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.fifo_cnt     = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
